// File: rtl/mod_counter_pkg.sv
// Shared types and parameter-legality helper for the mod_counter block.
// Optional feature macro used by mod_counter: MOD_COUNTER_SAT_EN.
package mod_counter_pkg;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

  // True when WIDTH, MAX_VAL and PRESCALE describe a buildable counter.
  function automatic bit params_ok(input int width, input longint max_val, input int prescale);
    longint top;
    if (width < 1 || width > 62 || prescale < 1) return 1'b0;
    top = (longint'(1) << width) - 1;
    return (max_val >= 1) && (max_val <= top);
  endfunction

endpackage

// File: rtl/mod_counter_tick_prescaler.sv
// tick_prescaler: emits one enabled-clock tick every PRESCALE enabled clocks.
// The phase counter freezes while en is low and restarts on clr or rst.
// With PRESCALE=1 the block is a pure pass-through of en.
module tick_prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  if (PRESCALE == 1) begin : g_pass
    logic unused;
    assign unused = &{1'b0, clk, rst, clr};
    assign tick   = en;
  end else begin : g_div
    localparam int PW = $clog2(PRESCALE);
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] pre_cnt;

    // Phase counter: 0..PRESCALE-1, advancing only on enabled clocks.
    always_ff @(posedge clk) begin
      if (rst) begin
        pre_cnt <= '0;
      end else if (clr) begin
        pre_cnt <= '0;
      end else if (en) begin
        if (pre_cnt == LAST) pre_cnt <= '0;
        else                 pre_cnt <= pre_cnt + PW'(1);
      end
    end

    assign tick = en && (pre_cnt == LAST);
  end

endmodule

// File: rtl/mod_counter.sv
// mod_counter: parametrised up/down modulo counter with synchronous load,
// enable, prescaler and a registered wrap pulse.
// Optional feature: define MOD_COUNTER_SAT_EN to add the sat_mode port, which
// makes the counter hold at its end values instead of wrapping.
module mod_counter
  import mod_counter_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int MAX_VAL  = 2**WIDTH - 1,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
`ifdef MOD_COUNTER_SAT_EN
  input  logic             sat_mode,
`endif
  output logic [WIDTH-1:0] count,
  output logic             wrap
);

  if (!params_ok(WIDTH, longint'(MAX_VAL), PRESCALE)) begin : g_bad_params
    $error("mod_counter: illegal WIDTH/MAX_VAL/PRESCALE combination");
  end

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_VAL);

  logic             tick;
  logic             sat;
  dir_e             dir;
  logic [WIDTH-1:0] load_clamped;
  logic [WIDTH-1:0] next_count;
  logic             next_wrap;

`ifdef MOD_COUNTER_SAT_EN
  assign sat = sat_mode;
`else
  assign sat = 1'b0;
`endif

  assign dir = dir_e'(up_dn);

  // Loads above the terminal value are clamped so no illegal state is reachable.
  assign load_clamped = (load_val > MAX_V) ? MAX_V : load_val;

  // The prescale period restarts whenever a load is taken.
  tick_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .clr  (load),
    .tick (tick)
  );

  // Next value for a step in the sampled direction, wrapping or saturating at the ends.
  always_comb begin
    next_count = count;
    next_wrap  = 1'b0;
    if (dir == DIR_UP) begin
      if (count == MAX_V) begin
        next_count = sat ? MAX_V : '0;
        next_wrap  = !sat;
      end else begin
        next_count = count + WIDTH'(1);
      end
    end else begin
      if (count == '0) begin
        next_count = sat ? '0 : MAX_V;
        next_wrap  = !sat;
      end else begin
        next_count = count - WIDTH'(1);
      end
    end
  end

  // Count register: reset beats load, load beats a step; wrap is a one-cycle pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      wrap  <= 1'b0;
    end else if (load) begin
      count <= load_clamped;
      wrap  <= 1'b0;
    end else if (tick) begin
      count <= next_count;
      wrap  <= next_wrap;
    end else begin
      wrap  <= 1'b0;
    end
  end

endmodule

// File: doc/mod_counter.md
# mod_counter

Parametrised up/down modulo counter with synchronous load, enable, prescaler and wrap flag. It replaces the fixed 4-bit free-running counter wherever a configurable width, modulus, count direction or reduced count rate is needed. Typical uses are timebases, event counters and display digit sequencing.

## Interface
- `WIDTH`, 8: counter width in bits; must be ≥ 1.
- `MAX_VAL`, 2**WIDTH-1: terminal value, so the modulus is MAX_VAL+1. Range 1 ≤ MAX_VAL ≤ 2**WIDTH-1.
- `PRESCALE`, 1: enabled clocks per count step; must be ≥ 1.

- `clk` input 1: single clock; all state updates on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `en` input 1: count enable; when low, the prescaler and the count both freeze.
- `up_dn` input 1: count direction; 1 = up, 0 = down.
- `load` input 1: synchronous load strobe.
- `load_val` input WIDTH: value written on `load`.
- `count` output WIDTH: current count (registered).
- `wrap` output 1: registered one-cycle pulse, coincident with `count` showing the wrapped value.
- `sat_mode` input 1: saturate instead of wrap. This port is present only with MOD_COUNTER_SAT_EN.

## Operation
- Priority order: `rst` > `load` > count step.
- Reset values: `count`=0, `wrap`=0, internal prescaler=0.
- Load:
  - `count` ← min(`load_val`, MAX_VAL).
  - Prescaler clears to 0.
  - `wrap` ← 0.
  - `en` is ignored during a load cycle.
- Prescaler:
  - Internal `pre_cnt` runs 0..PRESCALE-1 and advances only while `en`=1.
  - `tick` = `en` && (`pre_cnt` == PRESCALE-1).
  - With PRESCALE=1, `tick` = `en`.
- Step (on `tick`):
  - Up: `count` == MAX_VAL → 0 with `wrap`=1; otherwise `count`+1.
  - Down: `count` == 0 → MAX_VAL with `wrap`=1; otherwise `count`-1.
- `wrap` is 0 in every cycle without a wrapping step.
- `up_dn` is sampled at the tick edge only; changing it between ticks has no other effect.
- Arithmetic is WIDTH bits wide. No value above MAX_VAL is ever reachable.

## Timing
- `count` changes on the rising edge at which `tick` is high, so latency from `en` rising to the first step is PRESCALE edges.
- `load` takes effect on the next edge: 1-cycle latency.
- `rst` takes effect on the next edge. A reset mid-prescale discards the partial prescale count.
- `load` and `tick` in the same cycle: the load wins, no step is taken, and the prescale period restarts.
- Reversing direction at a boundary: for example, at `count`=0 switching from up to down wraps to MAX_VAL on the next tick.
- With `en` held high, the steady-state step rate is exactly one step every PRESCALE clocks.

## Configuration
- Macro `MOD_COUNTER_SAT_EN`.
- Defined:
  - The `sat_mode` port exists.
  - When `sat_mode`=1, the counter holds at MAX_VAL when counting up and at 0 when counting down, and `wrap` stays 0.
  - When `sat_mode`=0, behaviour is identical to the undefined case.
- Undefined: the port is absent and the counter always wraps.

## Structure
- Package `mod_counter_pkg` holds:
  - `typedef enum logic {DIR_DOWN=1'b0, DIR_UP=1'b1} dir_e`
  - The parameter-legality check function used by elaboration-time assertions on WIDTH, MAX_VAL and PRESCALE.
- One sub-module, `tick_prescaler`:
  - Parameter: PRESCALE.
  - Ports: `clk`, `rst`, `en`, `clr`, `tick`.
  - `clr` is driven by `load`.
  - With PRESCALE=1 it degenerates to a pass-through.

## Test plan
All scenarios use WIDTH=4, MAX_VAL=9, PRESCALE=1 unless noted.
- Reset: hold `rst` 2 cycles with `en`=1 → `count`=0 and `wrap`=0; the first step occurs one edge after `rst` is released.
- Up wrap: `en`=1, `up_dn`=1 for 12 clocks from 0 → count sequence 1..9,0,1,2, with `wrap`=1 only in the cycle `count`=0.
- Down wrap: load 0, then `up_dn`=0 → `count`=9 with `wrap`=1, then 8, 7.
- Load clamp and priority: `load_val`=13 with `load`=1 and `en`=1 → `count`=9 with no step that cycle; `load_val`=5 → 5.
- Prescale, PRESCALE=3: `en`=1 → `count` steps every 3rd edge. Drop `en` for 2 cycles mid-period → the step is delayed exactly 2 cycles. Assert `load` mid-period → the next step comes 3 edges after the load.
- MOD_COUNTER_SAT_EN defined, `sat_mode`=1: count up from 8 → 9,9,9 with `wrap`=0; down from 1 → 0,0.
